// File: rtl/mode_select_if.sv
// -----------------------------------------------------------------------------
// mode_select_if
//   Groups the button inputs and the mode outputs of mode_select.
//   master : board/button side, drives the raw buttons, observes the modes
//   slave  : mode_select itself
//   Signals
//     BTN_UP, BTN_DN, BTN_SEL : raw active-high buttons, asynchronous to CLK
//     MAIN_MODE, SUB_MODE     : 8-bit registered mode values
//     FIELD                   : field edited by UP/DN (0=MAIN_MODE, 1=SUB_MODE)
//     STEP                    : one-cycle pulse the cycle after a mode change
// -----------------------------------------------------------------------------
interface mode_select_if;
    logic       BTN_UP;
    logic       BTN_DN;
    logic       BTN_SEL;
    logic [7:0] MAIN_MODE;
    logic [7:0] SUB_MODE;
    logic       FIELD;
    logic       STEP;

    modport master (
        output BTN_UP, BTN_DN, BTN_SEL,
        input  MAIN_MODE, SUB_MODE, FIELD, STEP
    );

    modport slave (
        input  BTN_UP, BTN_DN, BTN_SEL,
        output MAIN_MODE, SUB_MODE, FIELD, STEP
    );
endinterface

// File: rtl/mode_select.sv
// -----------------------------------------------------------------------------
// mode_select
//   Push-button front end producing the MAIN_MODE/SUB_MODE pair used by the
//   7-seg display handler. Each raw button is synchronised (2 flops) and
//   debounced; a 0->1 edge of a debounced level is a press event. SEL toggles
//   the edited field, UP/DN step the edited field with wrap-around. Any change
//   of MAIN_MODE clears SUB_MODE.
//
//   Ports
//     RSTX  in  asynchronous active-low reset
//     CLK   in  clock
//     bus   mode_select_if.slave (BTN_UP/DN/SEL in, MAIN_MODE/SUB_MODE/FIELD/STEP out)
//
//   Build option
//     MODE_SELECT_AUTO_REPEAT_EN : when defined, a held UP or DN produces
//     extra steps after RPT_DLY cycles and then every RPT_PER cycles.
//     When undefined, one step per press.
// -----------------------------------------------------------------------------
module mode_select #(
    parameter int BW_DB    = 20,
    parameter int DB_CNT   = 500000,
    parameter int MAIN_MAX = 31,
    parameter int SUB_MAX  = 99,
    parameter int RPT_DLY  = 25000000,
    parameter int RPT_PER  = 5000000
) (
    input  logic         RSTX,
    input  logic         CLK,
    mode_select_if.slave bus
);

    // Button indices into the packed button vectors.
    localparam int NB    = 3;
    localparam int B_UP  = 0;
    localparam int B_DN  = 1;
    localparam int B_SEL = 2;

    localparam logic [BW_DB-1:0] DB_LAST  = BW_DB'(DB_CNT - 1);
    localparam logic [7:0]       MAIN_TOP = 8'(MAIN_MAX);
    localparam logic [7:0]       SUB_TOP  = 8'(SUB_MAX);

    // An illegal configuration leaves the buttons inert, so the outputs can
    // never leave their legal range whatever the parameters say.
    localparam bit PARAM_OK = (DB_CNT >= 2) && (MAIN_MAX >= 0) && (MAIN_MAX <= 255)
                           && (SUB_MAX >= 0) && (SUB_MAX <= 255)
                           && (RPT_DLY >= 1) && (RPT_PER >= 1);

    logic [NB-1:0] btn_raw;
    logic [NB-1:0] press;

    assign btn_raw = {bus.BTN_SEL, bus.BTN_DN, bus.BTN_UP};

    // -------------------------------------------------------------------------
    // Per-button synchroniser, debouncer and press-edge detector
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic             db_prev_reg;
            logic [BW_DB-1:0] cnt_reg;

            // The counter only runs while the synchronised level disagrees
            // with the accepted level; any agreement restarts it, so a glitch
            // shorter than DB_CNT cycles never flips db_reg.
            always_ff @(posedge CLK or negedge RSTX) begin
                if (!RSTX) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == DB_LAST) begin
                        db_reg  <= ~db_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + BW_DB'(1);
                    end
                end
            end

            // Only presses matter; releases produce no event.
            assign press[gi] = db_reg & ~db_prev_reg & PARAM_OK;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Auto-repeat
    // -------------------------------------------------------------------------
    logic rpt_up;
    logic rpt_dn;

`ifdef MODE_SELECT_AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
    localparam int BW_RPT  = $clog2(RPT_MAX + 1);
    localparam logic [BW_RPT-1:0] DLY_LAST = BW_RPT'(RPT_DLY - 1);
    localparam logic [BW_RPT-1:0] PER_LAST = BW_RPT'(RPT_PER - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_DELAY,
        RPT_PERIOD
    } rpt_state_t;

    rpt_state_t        rpt_state_reg;
    rpt_state_t        rpt_state_next;
    logic [BW_RPT-1:0] rpt_cnt_reg;
    logic [BW_RPT-1:0] rpt_cnt_next;
    logic              rpt_fire;
    logic              up_held;
    logic              dn_held;
    logic              one_held;
    logic              any_press;

    assign up_held   = g_btn[B_UP].db_reg;
    assign dn_held   = g_btn[B_DN].db_reg;
    // Repeats need exactly one of UP/DN held; holding both suppresses them.
    assign one_held  = up_held ^ dn_held;
    assign any_press = |press;

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            rpt_state_reg <= RPT_IDLE;
            rpt_cnt_reg   <= '0;
        end else begin
            rpt_state_reg <= rpt_state_next;
            rpt_cnt_reg   <= rpt_cnt_next;
        end
    end

    // The counter restarts from the initial delay on every press event
    // (UP, DN or SEL) and parks while not exactly one direction is held.
    // With the press on cycle c0 the counter reads 0 on c0+1, so the first
    // repeat fires on c0+RPT_DLY and the next ones every RPT_PER cycles.
    always_comb begin
        rpt_state_next = rpt_state_reg;
        rpt_cnt_next   = rpt_cnt_reg;
        rpt_fire       = 1'b0;
        if (!one_held || any_press) begin
            rpt_state_next = one_held ? RPT_DELAY : RPT_IDLE;
            rpt_cnt_next   = '0;
        end else begin
            case (rpt_state_reg)
                RPT_IDLE: begin
                    // The opposite button was just released: start afresh.
                    rpt_state_next = RPT_DELAY;
                    rpt_cnt_next   = '0;
                end
                RPT_DELAY: begin
                    if (rpt_cnt_reg == DLY_LAST) begin
                        rpt_fire       = 1'b1;
                        rpt_state_next = RPT_PERIOD;
                        rpt_cnt_next   = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + BW_RPT'(1);
                    end
                end
                RPT_PERIOD: begin
                    if (rpt_cnt_reg == PER_LAST) begin
                        rpt_fire     = 1'b1;
                        rpt_cnt_next = '0;
                    end else begin
                        rpt_cnt_next = rpt_cnt_reg + BW_RPT'(1);
                    end
                end
                default: begin
                    rpt_state_next = RPT_IDLE;
                    rpt_cnt_next   = '0;
                end
            endcase
        end
    end

    assign rpt_up = rpt_fire & up_held;
    assign rpt_dn = rpt_fire & dn_held;
`else
    // One step per press: no repeat events.
    assign rpt_up = 1'b0;
    assign rpt_dn = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Mode registers
    // -------------------------------------------------------------------------
    logic [7:0] main_mode_reg;
    logic [7:0] main_mode_next;
    logic [7:0] sub_mode_reg;
    logic [7:0] sub_mode_next;
    logic       field_reg;
    logic       field_next;
    logic       chg_reg;
    logic       chg_next;
    logic       step_reg;
    logic       up_evt;
    logic       dn_evt;
    logic       sel_evt;
    logic       do_up;
    logic       do_dn;

    assign up_evt  = press[B_UP] | rpt_up;
    assign dn_evt  = press[B_DN] | rpt_dn;
    assign sel_evt = press[B_SEL];
    // Simultaneous UP and DN cancel each other.
    assign do_up   = up_evt & ~dn_evt;
    assign do_dn   = dn_evt & ~up_evt;

    always_comb begin
        main_mode_next = main_mode_reg;
        sub_mode_next  = sub_mode_reg;
        // The step below uses field_reg, i.e. the field selected before a
        // SEL toggling on the same edge.
        field_next     = field_reg ^ sel_evt;
        if (do_up || do_dn) begin
            if (!field_reg) begin
                if (do_up) begin
                    main_mode_next = (main_mode_reg >= MAIN_TOP) ? 8'd0 : main_mode_reg + 8'd1;
                end else begin
                    main_mode_next = (main_mode_reg == 8'd0) ? MAIN_TOP : main_mode_reg - 8'd1;
                end
            end else begin
                if (do_up) begin
                    sub_mode_next = (sub_mode_reg >= SUB_TOP) ? 8'd0 : sub_mode_reg + 8'd1;
                end else begin
                    sub_mode_next = (sub_mode_reg == 8'd0) ? SUB_TOP : sub_mode_reg - 8'd1;
                end
            end
        end
        // A new main mode always starts from sub mode 0.
        if (main_mode_next != main_mode_reg) begin
            sub_mode_next = 8'd0;
        end
        chg_next = (main_mode_next != main_mode_reg) || (sub_mode_next != sub_mode_reg);
    end

    // chg_reg marks the cycle the new value is visible; STEP follows one
    // cycle later so the display side sees settled values with the pulse.
    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            main_mode_reg <= 8'd0;
            sub_mode_reg  <= 8'd0;
            field_reg     <= 1'b0;
            chg_reg       <= 1'b0;
            step_reg      <= 1'b0;
        end else begin
            main_mode_reg <= main_mode_next;
            sub_mode_reg  <= sub_mode_next;
            field_reg     <= field_next;
            chg_reg       <= chg_next;
            step_reg      <= chg_reg;
        end
    end

    assign bus.MAIN_MODE = main_mode_reg;
    assign bus.SUB_MODE  = sub_mode_reg;
    assign bus.FIELD     = field_reg;
    assign bus.STEP      = step_reg;

endmodule

// File: tb/tb_mode_select.sv
// -----------------------------------------------------------------------------
// tb_mode_select
//   Self-checking bench for mode_select (DB_CNT=4, RPT_DLY=20, RPT_PER=8,
//   MAIN_MAX=31, SUB_MAX=99). Each button action updates a small
//   sequence-level model and queues the expected mode triple for every STEP
//   pulse; a monitor pops and compares on each STEP.
// -----------------------------------------------------------------------------
module tb_mode_select;

    localparam int MAIN_MAX = 31;
    localparam int SUB_MAX  = 99;

    typedef struct packed {
        logic [7:0] main_mode;
        logic [7:0] sub_mode;
        logic       field;
    } exp_t;

    logic clk;
    logic rstx;

    mode_select_if bus_if ();

    mode_select #(
        .BW_DB    (20),
        .DB_CNT   (4),
        .MAIN_MAX (MAIN_MAX),
        .SUB_MAX  (SUB_MAX),
        .RPT_DLY  (20),
        .RPT_PER  (8)
    ) dut (
        .RSTX (rstx),
        .CLK  (clk),
        .bus  (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    int   m_main  = 0;
    int   m_sub   = 0;
    int   m_field = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Apply one simultaneous set of press events to the model and queue the
    // expected outputs if a mode changes.
    task automatic model_event(input bit up, input bit dn, input bit sel);
        bit   s_up;
        bit   s_dn;
        exp_t e;
        s_up = up && !dn;
        s_dn = dn && !up;
        if (s_up || s_dn) begin
            if (m_field == 0) begin
                if (s_up) m_main = (m_main == MAIN_MAX) ? 0 : m_main + 1;
                else      m_main = (m_main == 0) ? MAIN_MAX : m_main - 1;
                m_sub = 0;
            end else begin
                if (s_up) m_sub = (m_sub == SUB_MAX) ? 0 : m_sub + 1;
                else      m_sub = (m_sub == 0) ? SUB_MAX : m_sub - 1;
            end
        end
        if (sel) m_field = 1 - m_field;
        if (s_up || s_dn) begin
            e.main_mode = 8'(m_main);
            e.sub_mode  = 8'(m_sub);
            e.field     = 1'(m_field);
            exp_q.push_back(e);
        end
    endtask

    // Press raw buttons together for 'hold' cycles, release, let it settle.
    task automatic press_btns(input bit up, input bit dn, input bit sel, input int hold);
        @(negedge clk);
        bus_if.BTN_UP  = up;
        bus_if.BTN_DN  = dn;
        bus_if.BTN_SEL = sel;
        model_event(up, dn, sel);
        repeat (hold) @(negedge clk);
        bus_if.BTN_UP  = 1'b0;
        bus_if.BTN_DN  = 1'b0;
        bus_if.BTN_SEL = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    // Scoreboard monitor: every STEP pulse consumes one expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rstx && bus_if.STEP) begin
            if (exp_q.size() == 0) begin
                check_val("step_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                $display("[%0t] step main=%0d sub=%0d field=%0d (exp %0d/%0d/%0d)", $time,
                         bus_if.MAIN_MODE, bus_if.SUB_MODE, bus_if.FIELD,
                         e.main_mode, e.sub_mode, e.field);
                check_val("step_main", bus_if.MAIN_MODE, e.main_mode);
                check_val("step_sub", bus_if.SUB_MODE, e.sub_mode);
                check_val("step_field", bus_if.FIELD, e.field);
            end
        end
    end

    initial begin : stim
        int lat;
        int n_rpt;
        rstx           = 1'b0;
        bus_if.BTN_UP  = 1'b0;
        bus_if.BTN_DN  = 1'b0;
        bus_if.BTN_SEL = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_main", bus_if.MAIN_MODE, 0);
        check_val("rst_sub", bus_if.SUB_MODE, 0);
        check_val("rst_field", bus_if.FIELD, 0);
        check_val("rst_step", bus_if.STEP, 0);
        rstx = 1'b1;
        repeat (3) @(negedge clk);

        // 1. Short glitch is ignored; a proper press steps MAIN_MODE once.
        bus_if.BTN_UP = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.BTN_UP = 1'b0;
        repeat (15) @(negedge clk);
        check_val("glitch_main", bus_if.MAIN_MODE, 0);

        bus_if.BTN_UP = 1'b1;
        model_event(1, 0, 0);
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus_if.STEP) begin
                lat = i;
                break;
            end
        end
        check_val("step_latency", lat, 8);
        repeat (3) @(negedge clk);
        bus_if.BTN_UP = 1'b0;
        repeat (12) @(negedge clk);
        check_val("press1_main", bus_if.MAIN_MODE, 1);

        // 2. Wrap-around in both directions.
        press_btns(0, 1, 0, 10);   // 1 -> 0
        press_btns(0, 1, 0, 10);   // 0 -> 31
        check_val("wrap_dn_main", bus_if.MAIN_MODE, 31);
        press_btns(1, 0, 0, 10);   // 31 -> 0
        check_val("wrap_up_main", bus_if.MAIN_MODE, 0);

        // 3. SUB_MODE editing, and a main change clears it.
        press_btns(0, 0, 1, 10);
        check_val("sel_field", bus_if.FIELD, 1);
        for (int i = 0; i < 3; i++) press_btns(1, 0, 0, 10);
        check_val("sub_three", bus_if.SUB_MODE, 3);
        press_btns(0, 1, 0, 10);
        press_btns(1, 0, 0, 10);
        press_btns(0, 0, 1, 10);
        press_btns(1, 0, 0, 10);
        check_val("main_after_sub", bus_if.MAIN_MODE, 1);
        check_val("sub_cleared", bus_if.SUB_MODE, 0);

        // 4. UP and DN together cancel.
        press_btns(1, 1, 0, 10);
        check_val("updn_main", bus_if.MAIN_MODE, 1);
        check_val("updn_sub", bus_if.SUB_MODE, 0);

        // 5. SEL+UP together: step lands on MAIN, FIELD toggles.
        press_btns(1, 0, 1, 10);
        check_val("selup_main", bus_if.MAIN_MODE, 2);
        check_val("selup_field", bus_if.FIELD, 1);
        check_val("pending_mid", exp_q.size(), 0);

        // 6. Long hold (SUB field), then reset while still held.
`ifdef MODE_SELECT_AUTO_REPEAT_EN
        n_rpt = 4;
`else
        n_rpt = 0;
`endif
        @(negedge clk);
        bus_if.BTN_UP = 1'b1;
        model_event(1, 0, 0);
        for (int i = 0; i < n_rpt; i++) model_event(1, 0, 0);
        repeat (55) @(negedge clk);
        check_val("hold_sub", bus_if.SUB_MODE, n_rpt + 1);
        check_val("pending_hold", exp_q.size(), 0);
        #2 rstx = 1'b0;
        #1;
        check_val("rst_hold_main", bus_if.MAIN_MODE, 0);
        check_val("rst_hold_sub", bus_if.SUB_MODE, 0);
        check_val("rst_hold_field", bus_if.FIELD, 0);
        check_val("rst_hold_step", bus_if.STEP, 0);
        m_main  = 0;
        m_sub   = 0;
        m_field = 0;
        repeat (3) @(negedge clk);
        rstx = 1'b1;
        // Still-held UP is a fresh press once debounced.
        model_event(1, 0, 0);
        repeat (12) @(negedge clk);
        bus_if.BTN_UP = 1'b0;
        repeat (12) @(negedge clk);
        check_val("rehold_main", bus_if.MAIN_MODE, 1);
        check_val("pending_end", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
